// File: rtl/pipe_muldiv_pkg.sv
// Shared execute-stage definitions: mult/div opcodes, FSM states and the 8-bit
// trap codes also used by the ALU stage.
package pipe_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } md_state_t;

  localparam logic [7:0] TRAP_NONE    = 8'h00;
  localparam logic [7:0] TRAP_SYSCALL = 8'h08;
  localparam logic [7:0] TRAP_BREAK   = 8'h09;
  localparam logic [7:0] TRAP_RI      = 8'h0A;
  localparam logic [7:0] TRAP_OVF     = 8'h0C;
  localparam logic [7:0] TRAP_STALL   = 8'hF0;

endpackage

// File: rtl/pipe_muldiv_if.sv
// Request/response bundle between the execute-stage pipeline (master) and the
// multiply/divide unit (slave).
interface pipe_muldiv_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             flush;
  logic [7:0]       exception_in;
  logic             valid_in;
  md_op_t           op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic [WIDTH-1:0] out_val;
  logic             out_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [7:0]       exception;

  modport master (
    output flush, exception_in, valid_in, op, rs_val, rt_val,
    input  busy, out_val, out_valid, hi, lo, exception
  );

  modport slave (
    input  flush, exception_in, valid_in, op, rs_val, rt_val,
    output busy, out_val, out_valid, hi, lo, exception
  );
endinterface

// File: rtl/pipe_muldiv_iter_core.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per
// cycle on a shared {hi,lo} register; done is high during the last step.
module muldiv_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  logic               run;
  logic               mode_r;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               sub_ok;

  assign done   = run && (cnt == CNT_W'(WIDTH - 1));
  assign result = acc;

  // Multiply: upper half accumulates the multiplicand, then the pair shifts right.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  // Divide: the remainder's dropped MSB means the shifted value already exceeds the divisor.
  assign rem_sh  = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
  assign sub_ok  = acc[2*WIDTH-1] || (rem_sh >= opb);
  assign rem_sub = rem_sh - opb;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= {{WIDTH{1'b0}}, a};
      opb    <= b;
      mode_r <= mode;
    end else if (run) begin
      if (!mode_r)
        acc <= {sum, acc[WIDTH-1:1]};
      else if (sub_ok)
        acc <= {rem_sub, acc[WIDTH-2:0], 1'b1};
      else
        acc <= {rem_sh, acc[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/pipe_muldiv.sv
// Execute-stage MULT/DIV unit owning HI/LO, with busy interlock and stall trap.
// Define PIPE_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module pipe_muldiv
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst,
  pipe_muldiv_if.slave md
);
  md_state_t          state, state_nxt;
  logic               accept, start, iter_op, is_signed, is_div, core_done;
  logic               div_op, neg_lo, neg_hi;
  logic [WIDTH-1:0]   mag_a, mag_b, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] core_res, prod_fix;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return neg_if(v, sgn && v[WIDTH-1]);
  endfunction

  assign is_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign is_div    = (md.op == MD_DIV) || (md.op == MD_DIVU);
`ifdef PIPE_MULDIV_FAST_MUL_EN
  assign iter_op   = is_div;
`else
  assign iter_op   = is_div || (md.op == MD_MULT) || (md.op == MD_MULTU);
`endif
  assign accept  = md.valid_in && !rst && !md.flush &&
                   (md.exception_in == TRAP_NONE) && (state == IDLE);
  assign start   = accept && iter_op;
  assign mag_a   = mag(md.rs_val, is_signed);
  assign mag_b   = mag(md.rt_val, is_signed);
  assign md.busy = (state != IDLE);

  muldiv_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (md.flush),
    .mode   (is_div),
    .a      (mag_a),
    .b      (mag_b),
    .done   (core_done),
    .result (core_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (core_done) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (md.flush) state_nxt = IDLE;
  end

  // Sign fixup flags: quotient/product sign from both operands, remainder from the dividend.
  always_ff @(posedge clk) begin
    if (start) begin
      div_op <= is_div;
      neg_lo <= is_signed && (md.rs_val[WIDTH-1] ^ md.rt_val[WIDTH-1]);
      neg_hi <= is_signed && md.rs_val[WIDTH-1];
    end
  end

  always_comb begin
    prod_fix = neg_lo ? -core_res : core_res;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (div_op) begin
      fix_hi = neg_if(core_res[2*WIDTH-1:WIDTH], neg_hi);
      fix_lo = neg_if(core_res[WIDTH-1:0], neg_lo);
    end
  end

`ifdef PIPE_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  always_comb begin
    if (md.op == MD_MULT)
      fast_prod = $signed({{WIDTH{md.rs_val[WIDTH-1]}}, md.rs_val}) *
                  $signed({{WIDTH{md.rt_val[WIDTH-1]}}, md.rt_val});
    else
      fast_prod = {{WIDTH{1'b0}}, md.rs_val} * {{WIDTH{1'b0}}, md.rt_val};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      md.hi        <= '0;
      md.lo        <= '0;
      md.out_val   <= '0;
      md.out_valid <= 1'b0;
      md.exception <= TRAP_STALL;
    end else begin
      md.out_valid <= 1'b0;
      md.exception <= TRAP_NONE;
      if (!md.flush) begin
        if (md.exception_in != TRAP_NONE)
          md.exception <= md.exception_in;
        else if (md.valid_in && (state != IDLE))
          md.exception <= TRAP_STALL;
        if (state == FIXUP) begin
          md.hi <= fix_hi;
          md.lo <= fix_lo;
        end
        if (accept) begin
          case (md.op)
            MD_MFHI: begin md.out_val <= md.hi; md.out_valid <= 1'b1; end
            MD_MFLO: begin md.out_val <= md.lo; md.out_valid <= 1'b1; end
            MD_MTHI: md.hi <= md.rs_val;
            MD_MTLO: md.lo <= md.rs_val;
`ifdef PIPE_MULDIV_FAST_MUL_EN
            MD_MULT, MD_MULTU: {md.hi, md.lo} <= fast_prod;
`endif
            default: ;
          endcase
        end
      end
    end
  end
endmodule
